uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte producers (CPU TX FIFO, debug

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: sequencer states and byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
// Reusable for any shared peripheral; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        logic [IDX_W-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = IDX_W'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_j]) begin
                o_valid      = 1'b1;
                o_idx        = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin
// arbitration and optional burst locking; sequences start/busy handshakes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_req_lock,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ack,
    output logic                           o_tx_start,
    output logic [UART_BYTE_W-1:0]         o_tx_data,
    input  logic                           i_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     o_owner,
    output logic                           o_active,
    output logic                           o_timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr;
    logic [NUM_REQ-1:0]     r_grant_oh;
    logic [NUM_REQ-1:0]     r_req_ack;
    logic                   r_lock;
    logic                   r_tx_start;
    logic                   r_active;
    logic                   r_timeout_err;
    logic [UART_BYTE_W-1:0] r_tx_data;
    logic [CNT_W-1:0]       r_cnt;

    logic [UART_BYTE_W-1:0] w_bytes [NUM_REQ];
    logic                   w_lock_hold;
    logic                   w_lock_release;
    logic                   w_arb_valid;
    logic                   w_grant_valid;
    logic [IDX_W-1:0]       w_owner_next;
    logic [IDX_W-1:0]       w_arb_ptr;
    logic [IDX_W-1:0]       w_arb_idx;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [NUM_REQ-1:0]     w_arb_grant;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [NUM_REQ-1:0]     w_grant_oh;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = i_req_data[gi*UART_BYTE_W +: UART_BYTE_W];
    end

    // A held lock keeps the owner; a lock whose owner went quiet restarts the
    // rotation just past that owner so the burst owner does not win again.
    assign w_owner_next   = IDX_W'(wrap_inc(int'(r_owner), NUM_REQ));
    assign w_owner_oh     = NUM_REQ'(1) << r_owner;
    assign w_lock_hold    = r_lock & i_req[r_owner];
    assign w_lock_release = r_lock & ~i_req[r_owner];
    assign w_arb_ptr      = w_lock_release ? w_owner_next : r_rr;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (w_arb_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_grant_valid = w_lock_hold | w_arb_valid;
    assign w_grant_idx   = w_lock_hold ? r_owner : w_arb_idx;
    assign w_grant_oh    = w_lock_hold ? w_owner_oh : w_arb_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_rr          <= '0;
            r_grant_oh    <= '0;
            r_req_ack     <= '0;
            r_lock        <= 1'b0;
            r_tx_start    <= 1'b0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tx_data     <= '0;
            r_cnt         <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_req_ack  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_lock_release) begin
                        r_lock <= 1'b0;
                        r_rr   <= w_owner_next;
                    end
                    if (!i_tx_busy && w_grant_valid) begin
                        r_owner    <= w_grant_idx;
                        r_grant_oh <= w_grant_oh;
                        r_tx_data  <= w_bytes[w_grant_idx];
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tx_start <= 1'b1;
                    r_req_ack  <= r_grant_oh;
                    r_active   <= 1'b1;
                    r_lock     <= |(i_req_lock & r_grant_oh);
                    r_cnt      <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_lock        <= 1'b0;
                        r_active      <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                        if (!r_lock) begin
                            r_rr <= w_owner_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ack     = r_req_ack;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_owner       = r_owner;
    assign o_active      = r_active;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transfer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BW = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     lock = '0;
    logic [8*N-1:0]   data = '0;
    logic             busy = 1'b0;
    logic [N-1:0]     o_req_ack;
    logic             o_tx_start;
    logic [7:0]       o_tx_data;
    logic [1:0]       o_owner;
    logic             o_active;
    logic             o_timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (req),
        .i_req_lock    (lock),
        .i_req_data    (data),
        .o_req_ack     (o_req_ack),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .i_tx_busy     (busy),
        .o_owner       (o_owner),
        .o_active      (o_active),
        .o_timeout_err (o_timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // requesters: byte queues abstracted as a pending count plus current byte
    int         pend   [N];
    logic [7:0] byte_q [N];
    bit         rand_mode = 0;

    // UART core model: busy from u_rise to u_rise+u_len-1 cycles after tx_start
    int u_age  = -1;
    int u_rise = 2;
    int u_len  = 4;
    bit u_never = 0;
    bit u_rand  = 0;

    int log_owner[$];
    int log_data[$];
    int log_ack[$];
    int log_cyc[$];
    int to_cyc = -1;

    // reference model of the transfer sequence
    int         m_rr, m_owner, m_waited;
    bit         m_lock, m_timeout, m_active, m_pending, m_rise_wait, m_fall_wait;
    logic [7:0] m_data;
    int         e_start, e_ack;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_step();
        int g;
        e_start = 0;
        e_ack   = 0;
        if (rst) begin
            m_rr = 0; m_owner = 0; m_waited = 0; m_data = 8'h00;
            m_lock = 0; m_timeout = 0; m_active = 0;
            m_pending = 0; m_rise_wait = 0; m_fall_wait = 0;
            return;
        end
        if (m_pending) begin
            m_pending = 0; e_start = 1; e_ack = 1 << m_owner; m_active = 1;
            m_lock = lock[m_owner]; m_rise_wait = 1; m_waited = 0;
        end else if (m_rise_wait) begin
            if (busy) begin
                m_rise_wait = 0; m_fall_wait = 1;
            end else begin
                m_waited++;
                if (m_waited >= BW) begin
                    m_timeout = 1; m_lock = 0; m_active = 0; m_rise_wait = 0;
                end
            end
        end else if (m_fall_wait) begin
            if (!busy) begin
                m_fall_wait = 0; m_active = 0;
                if (!m_lock) m_rr = (m_owner + 1) % N;
            end
        end else begin
            if (m_lock && !req[m_owner]) begin
                m_lock = 0; m_rr = (m_owner + 1) % N;
            end
            if (!busy) begin
                g = m_lock ? m_owner : first_from(req, m_rr);
                if (g >= 0) begin
                    m_owner = g; m_data = data[g*8 +: 8]; m_pending = 1;
                end
            end
        end
    endfunction

    task automatic compare();
        chk("tx_start", int'(o_tx_start), e_start);
        chk("req_ack", int'(o_req_ack), e_ack);
        chk("tx_data", int'(o_tx_data), int'(m_data));
        chk("owner", int'(o_owner), m_owner);
        chk("active", int'(o_active), int'(m_active));
        chk("timeout_err", int'(o_timeout_err), int'(m_timeout));
    endtask

    task automatic apply_req();
        for (int i = 0; i < N; i++) begin
            req[i] = (pend[i] > 0);
            data[i*8 +: 8] = byte_q[i];
        end
    endtask

    task automatic observe();
        int i;
        if (o_tx_start) begin
            log_owner.push_back(int'(o_owner));
            log_data.push_back(int'(o_tx_data));
            log_ack.push_back(int'(o_req_ack));
            log_cyc.push_back(cyc);
        end
        if (o_timeout_err && to_cyc < 0) to_cyc = cyc;
        for (int k = 0; k < N; k++) begin
            if (o_req_ack[k] && pend[k] > 0) begin
                pend[k]--;
                if (rand_mode) byte_q[k] = 8'($urandom);
            end
        end
        if (o_tx_start) begin
            u_age = 0;
            if (u_rand) begin
                u_rise = ($urandom_range(0, 9) == 0) ? $urandom_range(0, BW + 3) : $urandom_range(0, 4);
                u_len  = $urandom_range(1, 12);
            end
        end else if (u_age >= 0) begin
            u_age++;
        end
        busy = !u_never && u_age >= u_rise && u_age < u_rise + u_len;
        if (u_age >= u_rise + u_len) u_age = -1;
        if (rand_mode) begin
            if ($urandom_range(0, 5) == 0) begin
                i = $urandom_range(0, N - 1);
                if (pend[i] < 3) pend[i]++;
            end
            if ($urandom_range(0, 15) == 0) begin
                i = $urandom_range(0, N - 1);
                lock[i] = ~lock[i];
            end
        end
        apply_req();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare();
        observe();
    endtask

    task automatic wait_launch(input int n, input int budget);
        int b = budget;
        while (log_owner.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk("launch_reached", int'(log_owner.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int b = budget;
        while ((o_active || busy || req != '0) && b > 0) begin
            tick();
            b--;
        end
        tick();
        tick();
        chk("idle_reached", int'(o_active || busy || req != '0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, c0, seen;
        int exp_o2[5] = '{0, 1, 2, 3, 0};
        int exp_d2[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        int exp_o4[4] = '{1, 1, 1, 0};
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            byte_q[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_owner", int'(o_owner), 0);
        chk("rst_tx_data", int'(o_tx_data), 0);
        rst = 1'b0;
        tick();

        // T2: all four requesting, round-robin order from pointer 0
        u_rise = 2; u_len = 3;
        for (int i = 0; i < N; i++) byte_q[i] = 8'h10 + 8'(i);
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 5, 200);
        for (int k = 0; k < 5; k++) begin
            if (b + k < log_owner.size()) begin
                chk("t2_owner", log_owner[b + k], exp_o2[k]);
                chk("t2_data", log_data[b + k], exp_d2[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (b + k + 1 < log_cyc.size())
                chk("t2_spacing", log_cyc[b + k + 1] - log_cyc[b + k], 8);
        end
        wait_idle(100);

        // T1: single byte, long busy
        u_rise = 2; u_len = 160;
        byte_q[0] = 8'hA5; pend[0] = 1;
        b = log_owner.size();
        c0 = cyc;
        apply_req();
        wait_launch(b + 1, 20);
        if (b < log_owner.size()) begin
            chk("t1_owner", log_owner[b], 0);
            chk("t1_data", log_data[b], 8'hA5);
            chk("t1_ack", log_ack[b], 1);
            chk("t1_latency", log_cyc[b] - c0, 2);
        end
        wait_idle(300);
        chk("t1_single_launch", log_owner.size(), b + 1);

        // T3: wrap-around from pointer 3
        u_len = 3;
        byte_q[2] = 8'h22; pend[2] = 1;
        apply_req();
        wait_idle(100);
        byte_q[3] = 8'h33; byte_q[0] = 8'h00; pend[3] = 1; pend[0] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 2, 100);
        if (b + 1 < log_owner.size()) begin
            chk("t3_first", log_owner[b], 3);
            chk("t3_second", log_owner[b + 1], 0);
        end
        wait_idle(100);

        // T4: locked burst of three from requester 1, then requester 0
        lock[1] = 1'b1;
        pend[1] = 3; pend[0] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 4, 200);
        for (int k = 0; k < 4; k++) begin
            if (b + k < log_owner.size()) chk("t4_owner", log_owner[b + k], exp_o4[k]);
        end
        wait_idle(100);
        lock = '0;
        tick();

        // T5: UART never goes busy
        u_never = 1;
        pend[0] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 1, 20);
        seen = 40;
        while (to_cyc < 0 && seen > 0) begin
            tick();
            seen--;
        end
        if (b < log_cyc.size()) chk("t5_timeout_delay", to_cyc - log_cyc[b], BW);
        chk("t5_inactive", int'(o_active), 0);
        u_never = 0;
        pend[1] = 1;
        apply_req();
        wait_launch(b + 2, 40);
        if (b + 1 < log_owner.size()) chk("t5_next_owner", log_owner[b + 1], 1);
        wait_idle(100);

        // T6: reset while the UART is busy
        u_rise = 1; u_len = 40;
        pend[2] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 1, 20);
        seen = 0;
        c0 = 60;
        while (seen < 3 && c0 > 0) begin
            tick();
            if (busy) seen++;
            c0--;
        end
        chk("t6_reach_done", seen, 3);
        rst = 1'b1;
        u_age = -1;
        busy = 1'b0;
        tick();
        chk("t6_tx_start", int'(o_tx_start), 0);
        chk("t6_req_ack", int'(o_req_ack), 0);
        chk("t6_tx_data", int'(o_tx_data), 0);
        chk("t6_owner", int'(o_owner), 0);
        chk("t6_active", int'(o_active), 0);
        chk("t6_timeout_err", int'(o_timeout_err), 0);
        rst = 1'b0;
        tick();
        u_rise = 2; u_len = 3;
        pend[0] = 1; pend[1] = 1;
        b = log_owner.size();
        apply_req();
        wait_launch(b + 1, 20);
        if (b < log_owner.size()) chk("t6_rr_restart", log_owner[b], 0);
        wait_idle(100);

        // randomized traffic, locks and UART timing
        rand_mode = 1;
        u_rand = 1;
        for (int i = 0; i < N; i++) byte_q[i] = 8'($urandom);
        apply_req();
        repeat (4000) tick();
        rand_mode = 0;
        lock = '0;
        wait_idle(2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
